// File: rtl/branch_redirect_ctrl.sv
// Fetch-side next-PC controller: owns the fetch PC, predicts with a direct-mapped
// BTB of 2-bit counters, and redirects/flushes/trains on execute-stage mispredicts.
module branch_redirect_ctrl #(
    parameter int          ENTRIES      = 16,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        ex_valid_i,
    input  logic        ex_is_branch_i,
    input  logic        ex_is_jump_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    output logic [31:0] pc_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    output logic        flush_o,
    output logic        misalign_o
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;
    localparam int CW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

    typedef enum logic {RUN, FLUSH} stateT;

    stateT          state, stateNext;
    logic [CW-1:0]  flushCnt, flushCntNext;
    logic [31:0]    pcNext;

    logic            btbValid  [ENTRIES];
    logic [1:0]      btbCtr    [ENTRIES];
    logic [TAGW-1:0] btbTag    [ENTRIES];
    logic [31:0]     btbTarget [ENTRIES];

    // Fetch-side lookup on the current PC
    logic [IDX-1:0]  fetchIdx;
    logic [TAGW-1:0] fetchTag;
    logic [31:0]     pcPlus4;

    assign fetchIdx      = pc_o[IDX+1:2];
    assign fetchTag      = pc_o[31:IDX+2];
    assign pcPlus4       = pc_o + 32'd4;
    assign pred_taken_o  = btbValid[fetchIdx] && (btbTag[fetchIdx] == fetchTag) && btbCtr[fetchIdx][1];
    assign pred_target_o = pred_taken_o ? btbTarget[fetchIdx] : pcPlus4;

    // Execute-side resolution
    logic            resolve, mispredict, exHit;
    logic [31:0]     correctedPc;
    logic [IDX-1:0]  exIdx;
    logic [TAGW-1:0] exTag;

    assign resolve     = ex_valid_i & (ex_is_branch_i | ex_is_jump_i) & (state == RUN);
    assign mispredict  = resolve & ((ex_taken_i != ex_pred_taken_i) |
                                    (ex_taken_i & ex_pred_taken_i & (ex_target_i != ex_pred_target_i)));
    assign correctedPc = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
    assign exIdx       = ex_pc_i[IDX+1:2];
    assign exTag       = ex_pc_i[31:IDX+2];
    assign exHit       = btbValid[exIdx] && (btbTag[exIdx] == exTag);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        stateNext    = state;
        flushCntNext = flushCnt;
        case (state)
            RUN: begin
                if (mispredict) begin
                    stateNext    = FLUSH;
                    flushCntNext = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (flushCnt == '0) stateNext = RUN;
                else                flushCntNext = flushCnt - CW'(1);
            end
            default: stateNext = RUN;
        endcase
    end

    always_comb begin
        pcNext = pred_target_o;
        if (mispredict)   pcNext = correctedPc;
        else if (stall_i) pcNext = pc_o;
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flushCnt   <= '0;
            pc_o       <= RESET_PC;
            flush_o    <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            state      <= stateNext;
            flushCnt   <= flushCntNext;
            pc_o       <= pcNext;
            flush_o    <= (stateNext == FLUSH);
            misalign_o <= mispredict & (correctedPc[1:0] != 2'b00);
        end
    end

    // Valid bits and counters are control state and must come out of reset clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btbValid[i] <= 1'b0;
                btbCtr[i]   <= 2'b01;
            end
        end else if (resolve) begin
            if (exHit) begin
                if (ex_taken_i && btbCtr[exIdx] != 2'b11)
                    btbCtr[exIdx] <= btbCtr[exIdx] + 2'd1;
                else if (!ex_taken_i && btbCtr[exIdx] != 2'b00)
                    btbCtr[exIdx] <= btbCtr[exIdx] - 2'd1;
            end else if (ex_taken_i) begin
                btbValid[exIdx] <= 1'b1;
                btbCtr[exIdx]   <= ex_is_jump_i ? 2'b11 : 2'b10;
            end
        end
    end

    // NOTE: tag/target storage is deliberately not reset; it is only observed behind a set valid bit.
    always_ff @(posedge clk) begin
        if (resolve && ex_taken_i) begin
            btbTag[exIdx]    <= exTag;
            btbTarget[exIdx] <= ex_target_i;
        end
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed vector table, reset-in-flush
// sequence, and randomized traffic against a behavioural next-PC/BTB model.
module tb_branch_redirect_ctrl;
    localparam int          ENTRIES      = 16;
    localparam int          FLUSH_CYCLES = 2;
    localparam logic [31:0] RESET_PC     = 32'h0000_0100;

    logic        clk, rst_n, stall_i, ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i;
    logic [31:0] ex_target_i, ex_pc_i, ex_pred_target_i;
    logic        ex_pred_taken_i;
    logic [31:0] pc_o, pred_target_o;
    logic        pred_taken_o, flush_o, misalign_o;

    branch_redirect_ctrl #(.ENTRIES(ENTRIES), .FLUSH_CYCLES(FLUSH_CYCLES), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
        .ex_is_branch_i(ex_is_branch_i), .ex_is_jump_i(ex_is_jump_i), .ex_taken_i(ex_taken_i),
        .ex_target_i(ex_target_i), .ex_pc_i(ex_pc_i), .ex_pred_taken_i(ex_pred_taken_i),
        .ex_pred_target_i(ex_pred_target_i), .pc_o(pc_o), .pred_taken_o(pred_taken_o),
        .pred_target_o(pred_target_o), .flush_o(flush_o), .misalign_o(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall, valid, isBr, isJmp, taken;
        logic [31:0] target, exPc;
        logic        predTaken;
        logic [31:0] predTarget;
        logic [31:0] expPc;
        logic        expFlush, expPt;
        logic [31:0] expPtg;
        logic        expMis;
    } vecT;

    vecT vecs [30];

    function automatic vecT mk(input logic s, input logic va, input logic br, input logic jp,
                               input logic tk, input logic [31:0] tg, input logic [31:0] epc,
                               input logic pt, input logic [31:0] ptg, input logic [31:0] ePc,
                               input logic eFl, input logic ePt, input logic [31:0] ePtg,
                               input logic eMis);
        vecT r;
        r.stall = s; r.valid = va; r.isBr = br; r.isJmp = jp; r.taken = tk;
        r.target = tg; r.exPc = epc; r.predTaken = pt; r.predTarget = ptg;
        r.expPc = ePc; r.expFlush = eFl; r.expPt = ePt; r.expPtg = ePtg; r.expMis = eMis;
        return r;
    endfunction

    function automatic vecT idle(input logic s, input logic [31:0] ePc, input logic eFl,
                                 input logic ePt, input logic [31:0] ePtg, input logic eMis);
        return mk(s, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, ePc, eFl, ePt, ePtg, eMis);
    endfunction

    task automatic drive(input logic s, input logic va, input logic br, input logic jp,
                         input logic tk, input logic [31:0] tg, input logic [31:0] epc,
                         input logic pt, input logic [31:0] ptg);
        stall_i = s; ex_valid_i = va; ex_is_branch_i = br; ex_is_jump_i = jp; ex_taken_i = tk;
        ex_target_i = tg; ex_pc_i = epc; ex_pred_taken_i = pt; ex_pred_target_i = ptg;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Behavioural model: flushLeft counts remaining flush cycles, tags kept as pc/(4*ENTRIES)
    int          flushLeft;
    logic [31:0] mPc;
    logic        mMis;
    logic        mValid  [ENTRIES];
    logic [31:0] mTag    [ENTRIES];
    logic [31:0] mTarget [ENTRIES];
    int          mCtr    [ENTRIES];

    task automatic modelReset();
        flushLeft = 0; mPc = RESET_PC; mMis = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 1'b0; mCtr[i] = 1; mTag[i] = 0; mTarget[i] = 0;
        end
    endtask

    task automatic modelPredict(input logic [31:0] pc, output logic pt, output logic [31:0] ptg);
        int idx;
        idx = int'((pc / 4) % ENTRIES);
        pt  = mValid[idx] && (mTag[idx] == pc / (4 * ENTRIES)) && (mCtr[idx] >= 2);
        ptg = pt ? mTarget[idx] : pc + 32'd4;
    endtask

    task automatic modelStep(input logic pt, input logic [31:0] ptg);
        logic        res, mis;
        logic [31:0] corr;
        int          idx;
        logic        hit;
        res  = ex_valid_i && (ex_is_branch_i || ex_is_jump_i) && (flushLeft == 0);
        mis  = res && ((ex_taken_i != ex_pred_taken_i) ||
                       (ex_taken_i && ex_target_i != ex_pred_target_i));
        corr = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
        if (res) begin
            idx = int'((ex_pc_i / 4) % ENTRIES);
            hit = mValid[idx] && (mTag[idx] == ex_pc_i / (4 * ENTRIES));
            if (hit) begin
                mCtr[idx] = ex_taken_i ? ((mCtr[idx] < 3) ? mCtr[idx] + 1 : 3)
                                       : ((mCtr[idx] > 0) ? mCtr[idx] - 1 : 0);
                if (ex_taken_i) mTarget[idx] = ex_target_i;
            end else if (ex_taken_i) begin
                mValid[idx]  = 1'b1;
                mTag[idx]    = ex_pc_i / (4 * ENTRIES);
                mTarget[idx] = ex_target_i;
                mCtr[idx]    = ex_is_jump_i ? 3 : 2;
            end
        end
        if (mis)          mPc = corr;
        else if (stall_i) mPc = mPc;
        else              mPc = ptg;
        flushLeft = mis ? FLUSH_CYCLES : ((flushLeft > 0) ? flushLeft - 1 : 0);
        mMis      = mis && (corr % 4 != 0);
    endtask

    function automatic logic [31:0] pickAddr(input logic [31:0] cur);
        case ($urandom_range(0, 5))
            0:       return 32'h104;
            1:       return 32'h144;
            2:       return 32'h200;
            3:       return cur;
            4:       return {20'h0, $urandom_range(0, 1023) * 4};
            default: return ($urandom_range(0, 7) == 0) ? {20'h0, 12'($urandom_range(0, 4095))} : 32'h300;
        endcase
    endfunction

    initial begin
        // Directed table: inputs presented in cycle k, outputs expected during cycle k
        vecs[0]  = idle(0, 32'h100, 0, 0, 32'h104, 0);
        vecs[1]  = idle(0, 32'h104, 0, 0, 32'h108, 0);
        vecs[2]  = idle(0, 32'h108, 0, 0, 32'h10C, 0);
        vecs[3]  = mk(0, 1, 1, 0, 1, 32'h200, 32'h104, 0, 32'h0,   32'h10C, 0, 0, 32'h110, 0);
        vecs[4]  = idle(0, 32'h200, 1, 0, 32'h204, 0);
        vecs[5]  = idle(0, 32'h204, 1, 0, 32'h208, 0);
        vecs[6]  = mk(0, 1, 1, 0, 0, 32'h0,   32'h100, 1, 32'h180, 32'h208, 0, 0, 32'h20C, 0);
        vecs[7]  = idle(0, 32'h104, 1, 1, 32'h200, 0);
        vecs[8]  = idle(0, 32'h200, 1, 0, 32'h204, 0);
        vecs[9]  = mk(0, 1, 1, 0, 0, 32'h0,   32'h104, 1, 32'h200, 32'h204, 0, 0, 32'h208, 0);
        vecs[10] = idle(0, 32'h108, 1, 0, 32'h10C, 0);
        vecs[11] = idle(0, 32'h10C, 1, 0, 32'h110, 0);
        vecs[12] = mk(0, 1, 1, 0, 0, 32'h0,   32'h104, 0, 32'h0,   32'h110, 0, 0, 32'h114, 0);
        vecs[13] = mk(0, 1, 1, 0, 0, 32'h0,   32'h104, 0, 32'h0,   32'h114, 0, 0, 32'h118, 0);
        vecs[14] = mk(0, 1, 1, 0, 1, 32'h200, 32'h104, 1, 32'h200, 32'h118, 0, 0, 32'h11C, 0);
        vecs[15] = mk(1, 1, 1, 0, 0, 32'h0,   32'h100, 1, 32'h180, 32'h11C, 0, 0, 32'h120, 0);
        vecs[16] = mk(0, 1, 1, 0, 1, 32'h300, 32'h104, 0, 32'h0,   32'h104, 1, 0, 32'h108, 0);
        vecs[17] = idle(0, 32'h108, 1, 0, 32'h10C, 0);
        vecs[18] = mk(0, 1, 1, 0, 0, 32'h0,   32'h100, 1, 32'h180, 32'h10C, 0, 0, 32'h110, 0);
        vecs[19] = idle(1, 32'h104, 1, 0, 32'h108, 0);
        vecs[20] = idle(0, 32'h104, 1, 0, 32'h108, 0);
        vecs[21] = mk(0, 1, 1, 0, 1, 32'h200, 32'h104, 1, 32'h300, 32'h108, 0, 0, 32'h10C, 0);
        vecs[22] = idle(0, 32'h200, 1, 0, 32'h204, 0);
        vecs[23] = idle(0, 32'h204, 1, 0, 32'h208, 0);
        vecs[24] = mk(0, 1, 0, 1, 1, 32'h1002, 32'h400, 0, 32'h0,  32'h208, 0, 0, 32'h20C, 0);
        vecs[25] = idle(0, 32'h1002, 1, 0, 32'h1006, 1);
        vecs[26] = idle(0, 32'h1006, 1, 0, 32'h100A, 0);
        vecs[27] = idle(1, 32'h100A, 0, 0, 32'h100E, 0);
        vecs[28] = idle(0, 32'h100A, 0, 0, 32'h100E, 0);
        vecs[29] = idle(0, 32'h100E, 0, 0, 32'h1012, 0);

        doReset();
        for (int k = 0; k < 30; k++) begin
            drive(vecs[k].stall, vecs[k].valid, vecs[k].isBr, vecs[k].isJmp, vecs[k].taken,
                  vecs[k].target, vecs[k].exPc, vecs[k].predTaken, vecs[k].predTarget);
            @(negedge clk);
            check($sformatf("c%0d pc", k),     pc_o,          vecs[k].expPc);
            check($sformatf("c%0d flush", k),  32'(flush_o),      32'(vecs[k].expFlush));
            check($sformatf("c%0d ptaken", k), 32'(pred_taken_o), 32'(vecs[k].expPt));
            check($sformatf("c%0d ptarget", k), pred_target_o, vecs[k].expPtg);
            check($sformatf("c%0d misalign", k), 32'(misalign_o), 32'(vecs[k].expMis));
            @(posedge clk);
            #1;
        end

        // Reset asserted in the middle of a flush window
        drive(0, 1, 1, 0, 1, 32'h500, 32'h104, 0, 32'h0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rstflush pre flush", 32'(flush_o), 32'd1);
        check("rstflush pre pc",    pc_o,         32'h500);
        #2 rst_n = 1'b0;
        #1;
        check("rstflush flush", 32'(flush_o),    32'd0);
        check("rstflush pc",    pc_o,            RESET_PC);
        check("rstflush mis",   32'(misalign_o), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("after rst pc0", pc_o, 32'h100);
        @(negedge clk);
        check("after rst pc1",     pc_o,              32'h104);
        check("after rst btb clr", 32'(pred_taken_o), 32'd0);
        check("after rst ptarget", pred_target_o,     32'h108);

        // Randomized traffic against the model
        doReset();
        modelReset();
        for (int n = 0; n < 400; n++) begin
            logic        pt, isBr, isJmp, tk;
            logic [31:0] ptg, tg;
            int          kind;
            kind  = $urandom_range(0, 2);
            isBr  = (kind == 1);
            isJmp = (kind == 2);
            tk    = isJmp ? 1'b1 : 1'($urandom_range(0, 1));
            tg    = pickAddr(mPc);
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), isBr, isJmp, tk,
                  tg, pickAddr(mPc), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? tg : pickAddr(mPc));
            modelPredict(mPc, pt, ptg);
            @(negedge clk);
            check($sformatf("r%0d pc", n),       pc_o,              mPc);
            check($sformatf("r%0d flush", n),    32'(flush_o),      32'(flushLeft > 0));
            check($sformatf("r%0d ptaken", n),   32'(pred_taken_o), 32'(pt));
            check($sformatf("r%0d ptarget", n),  pred_target_o,     ptg);
            check($sformatf("r%0d misalign", n), 32'(misalign_o),   32'(mMis));
            modelStep(pt, ptg);
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Fetch-side next-PC controller that sequences the program counter around the execute-stage branch unit. It owns the fetch PC register, predicts taken branches and jumps with a small direct-mapped branch target buffer (BTB) of 2-bit saturating counters, and compares each execute-stage resolution against the prediction that travelled with the instruction. On a mispredict it redirects fetch to the corrected PC, flushes the younger pipeline stages for a fixed number of cycles, and trains the BTB.

## Interface
- ENTRIES, 16, BTB entries; power of two, at least 2; IDX = log2(ENTRIES)
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect; at least 1
- RESET_PC, 32'h0000_0000, fetch PC after reset
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold the fetch PC (downstream not ready)
- ex_valid_i  in  1  the execute stage holds a valid instruction
- ex_is_branch_i  in  1  the execute instruction is a conditional branch
- ex_is_jump_i  in  1  the execute instruction is JAL or JALR
- ex_taken_i  in  1  resolved outcome from the branch unit (branch taken, or any jump)
- ex_target_i  in  32  resolved target from the branch unit
- ex_pc_i  in  32  PC of the execute instruction
- ex_pred_taken_i  in  1  prediction carried down the pipe with the instruction
- ex_pred_target_i  in  32  predicted target carried down the pipe
- pc_o  out  32  current fetch PC (registered)
- pred_taken_o  out  1  BTB predicts taken for pc_o (combinational from pc_o and the BTB)
- pred_target_o  out  32  predicted target for pc_o; equals pc_o+4 when not predicted taken
- flush_o  out  1  kill the IF and ID stages (registered)
- misalign_o  out  1  one-cycle pulse: the redirect target has target[1:0] != 0

## Operation
- resolve = ex_valid_i & (ex_is_branch_i | ex_is_jump_i) & (state == RUN).
- mispredict = resolve & ((ex_taken_i != ex_pred_taken_i) | (ex_taken_i & ex_pred_taken_i & ex_target_i != ex_pred_target_i)).
- Corrected PC = ex_taken_i ? ex_target_i : ex_pc_i + 4. All additions are 32-bit and wrap modulo 2^32.
- BTB index = pc[IDX+1:2]; tag = pc[31:IDX+2]. Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Prediction: taken if the entry is valid, its tag matches, and ctr[1] = 1.
- State machine has two states:
  - RUN: the normal state.
  - FLUSH: holds flush_o high for FLUSH_CYCLES cycles. A down-counter loads FLUSH_CYCLES-1 on entry and FLUSH returns to RUN when the counter reaches 0.
  - RUN -> FLUSH on mispredict.
  - In FLUSH, ex_valid_i is ignored: no resolve, no training, no further redirect.
- Next-PC priority:
  1. mispredict: corrected PC
  2. stall_i: hold pc_o
  3. pred_taken_o: pred_target_o
  4. otherwise: pc_o + 4
  - A redirect overrides stall_i.
  - In FLUSH, the PC advances per rules 2-4.
- BTB training happens on every resolve.
  - Index and tag hit: ctr saturating-increments if ex_taken_i, else saturating-decrements. target is rewritten with ex_target_i when taken.
  - Miss and taken: allocate the entry with valid=1, the new tag, target=ex_target_i, and ctr=2'b11 for a jump or 2'b10 for a branch.
  - Miss and not taken: no change.
- misalign_o pulses together with the redirect when the corrected PC has bits [1:0] != 0. The redirect still happens.

## Timing
- Reset values (asynchronous):
  - pc_o = RESET_PC, state = RUN, flush_o = 0, misalign_o = 0.
  - All BTB valid bits = 0 and all counters = 2'b01.
  - Target and tag fields are don't-care.
- Mispredict seen in cycle t: in cycle t+1, pc_o = corrected PC and flush_o = 1. flush_o stays high through cycle t+FLUSH_CYCLES and is 0 in cycle t+FLUSH_CYCLES+1.
- BTB writes land at the edge ending the resolve cycle. A fetch lookup in the same cycle at the same index sees the old contents.
- Prediction outputs have zero cycles of latency relative to pc_o.
- Reset asserted mid-FLUSH returns the block immediately to the reset values and discards all prediction state.

## Test plan
- Reset with RESET_PC=32'h100, no resolves for 3 cycles -> pc_o steps through 0x100, 0x104, 0x108, 0x10C; flush_o=0 throughout.
- Taken branch at ex_pc=0x104 to 0x200 with ex_pred_taken=0 -> next cycle pc_o=0x200, flush_o high for exactly 2 cycles. The BTB entry is allocated with ctr=10, so a later fetch at 0x104 gives pred_taken_o=1 and pred_target_o=0x200.
- Same branch later resolves not taken with ex_pred_taken=1 -> pc_o=0x108 and a flush. A further not-taken resolve drops ctr 01->00; a later resolve at 00 stays at 00 (saturation).
- Correctly predicted taken branch with matching target -> no flush, pc_o unaffected. The same prediction with ex_pred_target=0x300 but ex_target=0x200 -> redirect to 0x200.
- stall_i=1 during a mispredict -> the redirect still happens. stall_i=1 otherwise -> pc_o holds. A second mispredict presented during FLUSH -> ignored, and the BTB is unchanged.
- JALR with target 0x1002 -> pc_o=0x1002 with a misalign_o pulse. rst_n dropped during FLUSH -> flush_o=0 and pc_o=RESET_PC immediately.
